// File: rtl/regfile_mux_n_if.sv
// Write/read bus of the multi-port register file: one write port plus
// N_READ packed read ports with per-port valid.
interface regfile_mux_n_if #(
    parameter int unsigned N_BITS    = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned N_READ    = 2
);
    logic                          we;
    logic [ADDR_BITS-1:0]          waddr;
    logic [N_BITS-1:0]             wdata;
    logic [N_READ*ADDR_BITS-1:0]   raddr;
    logic [N_READ*N_BITS-1:0]      rdata;
    logic [N_READ-1:0]             rvalid;

    modport master (
        output we, waddr, wdata, raddr,
        input  rdata, rvalid
    );

    modport slave (
        input  we, waddr, wdata, raddr,
        output rdata, rvalid
    );
endinterface

// File: rtl/regfile_mux_n.sv
// Parametrised multi-port register file: N_REGS-to-1 read selectors per port,
// optional hardwired zero register, write-to-read bypass and registered read.
module regfile_mux_n #(
    parameter int unsigned N_BITS    = 32,
    parameter int unsigned N_REGS    = 32,
    parameter int unsigned ADDR_BITS = 5,
    parameter int unsigned N_READ    = 2,
    parameter int unsigned ZERO_REG  = 1,
    parameter int unsigned BYPASS    = 1,
    parameter int unsigned REG_READ  = 0
) (
    input  logic            clk,
    input  logic            rst,
    regfile_mux_n_if.slave  bus
);

    logic [N_BITS-1:0]              regs_q [N_REGS];
    logic                           wr_ok;
    logic [N_READ-1:0][N_BITS-1:0]  sel;

    // Writes to a hardwired register 0 are discarded and never forwarded.
    always_comb begin
        wr_ok = bus.we;
        if ((ZERO_REG != 0) && (bus.waddr == '0)) begin
            wr_ok = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[bus.waddr] <= bus.wdata;
        end
    end

    always_comb begin
        logic [ADDR_BITS-1:0] ra;
        sel = '0;
        ra  = '0;
        for (int unsigned k = 0; k < N_READ; k++) begin
            ra     = bus.raddr[k*ADDR_BITS +: ADDR_BITS];
            sel[k] = regs_q[ra];
            if ((ZERO_REG != 0) && (ra == '0)) begin
                sel[k] = '0;
            end
            if ((BYPASS != 0) && wr_ok && (bus.waddr == ra)) begin
                sel[k] = bus.wdata;
            end
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [N_READ*N_BITS-1:0] rdata_q;
            logic [N_READ-1:0]        rvalid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_q  <= '0;
                    rvalid_q <= '0;
                end else begin
                    rdata_q  <= sel;
                    rvalid_q <= '1;
                end
            end

            assign bus.rdata  = rdata_q;
            assign bus.rvalid = rvalid_q;
        end else begin : g_comb_read
            assign bus.rdata  = sel;
            assign bus.rvalid = '1;
        end
    endgenerate

endmodule
